spi_master: RTL and testbench
=============================

# spi_master

Parametrised SPI master with a memory-mapped register interface on the 8-bit peripheral bus. It supports all four SPI modes (CPOL/CPHA), a programmable SCK divider and up to four slave-select lines, and reports transfer completion with a sticky done flag. It is the general-purpose successor to the fixed-mode, fixed-rate SPI peripheral and sits on the same bus next to the other peripherals.

## Interface
- NUM_SS, 1, number of slave-select lines (1..4)
- DIV_RESET, 8'd3, reset value of the divider register

- i_clk  in  1  system clock
- i_reset  in  1  reset, synchronous, active-high
- i_addr  in  2  register address
- i_cs  in  1  chip select; a bus access occurs when i_cs is high at a rising edge of i_clk
- i_we  in  1  write enable (qualified by i_cs)
- i_dat  in  8  write data
- o_dat  out  8  read data, combinational from i_addr
- i_miso  in  1  serial data in
- o_mosi  out  1  serial data out
- o_sck  out  1  serial clock
- o_ss_n  out  NUM_SS  slave selects, active-low

## Operation
- Register map:
  - 0 CTRL, rw: [3:0] SS enables (bit k = 1 drives o_ss_n[k] low; bits ≥ NUM_SS read 0); [4] CPOL; [5] CPHA; [6] LSB-first (see Configuration); [7] reads 0.
  - 1 DIV, rw: SCK half-period = DIV+1 i_clk cycles.
  - 2 STATUS: [7] busy (ro); [6] done (sticky). Writing 1 to bit 6 clears done. All other bits read 0.
  - 3 DATA: write loads the TX shift register and starts a transfer; read returns the last received byte.
- While busy: writes to CTRL update only the SS bits; writes to CPOL/CPHA/LSB bits, DIV and DATA are ignored.
- States: IDLE, RUN. Starting in IDLE moves to RUN, clears done and resets the divider counter and the edge index (0..15).
- In RUN, the divider counter counts 0..DIV. At its terminal count a tick occurs: o_sck toggles and the edge index increments. Even edge indexes are leading edges; odd indexes are trailing edges.
- CPHA=0:
  - MSB is driven on o_mosi in the first RUN cycle.
  - i_miso is sampled on each leading edge.
  - The next bit is shifted out on each trailing edge except edge 15.
- CPHA=1:
  - A bit is shifted out on each leading edge.
  - i_miso is sampled on each trailing edge.
- After the tick at edge 15: return to IDLE, set done, copy the shift register to RX data. o_sck is back at CPOL.
- In IDLE, o_sck equals CPOL and tracks CPOL writes immediately. o_mosi holds its last value.

## Timing
- Reset values:
  - o_sck = 0, o_mosi = 0, o_ss_n = all 1s, o_dat reflects registers.
  - CTRL = 0, DIV = DIV_RESET, RX data = 0, busy = 0, done = 0.
- A DATA write at edge N gives busy = 1 from N+1. The 16 ticks occur at N+(k+1)·(DIV+1), k = 0..15.
- busy falls and done rises in the cycle after the last tick, at N+16·(DIV+1)+1. RX data is valid from that cycle.
- SS writes take effect on o_ss_n one cycle after the write.
- Done-clear and the done-set from a completing transfer in the same cycle: the set wins.
- Reset mid-transfer aborts on the next edge and restores all reset values. There is no partial RX update.
- DIV = 0 gives SCK = i_clk/2. DIV = 255 gives SCK = i_clk/512.

## Configuration
- SPI_LSB_FIRST_EN:
  - Defined: CTRL[6] is writable. When it is 1, bits are shifted out LSB first, and received bits fill from MSB toward LSB so the byte order is preserved.
  - Undefined: CTRL[6] reads 0, writes have no effect, and transfers are always MSB first.

## Test plan
- Mode 0, DIV = 0, i_miso looped to o_mosi, write DATA = 0xA5 → 8 SCK pulses starting low. busy high for exactly 16 cycles, done = 1, DATA reads 0xA5.
- Mode 3 (CTRL = 0x31), DIV = 3, slave returns 0x3C → o_sck idles high, 64-cycle transfer, o_ss_n[0] = 0 throughout, RX = 0x3C. MOSI changes only on falling SCK edges.
- Write DATA = 0x55 while busy with 0xF0, and write DIV = 9 while busy → transfer continues sending 0xF0, DIV still reads 3.
- Assert i_reset at the 5th tick → next cycle o_sck = 0, o_ss_n = all 1s, busy = 0, DATA reads 0x00, DIV reads DIV_RESET.
- Done set, then write STATUS = 0x40 → done reads 0. Clear issued in the completing cycle → done reads 1.
- With SPI_LSB_FIRST_EN, CTRL[6] = 1, loopback with 0x01 → the first MOSI bit is 1, RX = 0x01. Without the macro, CTRL reads back bit 6 = 0.

Source files
------------

// File: rtl/spi_master_if.sv
// spi_master_if: 8-bit peripheral bus between a bus master (CPU side) and the SPI master registers.
// The register read port is combinational from i_addr.
interface spi_master_if;
    logic [1:0] i_addr;
    logic       i_cs;
    logic       i_we;
    logic [7:0] i_dat;
    logic [7:0] o_dat;

    modport master (output i_addr, i_cs, i_we, i_dat, input o_dat);
    modport slave  (input i_addr, i_cs, i_we, i_dat, output o_dat);
endinterface

// File: rtl/spi_master.sv
// spi_master: register-mapped SPI master with all four SPI modes, programmable SCK divider and NUM_SS selects.
// Define SPI_LSB_FIRST_EN to make CTRL[6] (LSB-first shifting) writable; otherwise transfers are MSB first.
module spi_master #(
    parameter int         NUM_SS    = 1,
    parameter logic [7:0] DIV_RESET = 8'd3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    spi_master_if.slave       bus,
    input  logic              i_miso,
    output logic              o_mosi,
    output logic              o_sck,
    output logic [NUM_SS-1:0] o_ss_n
);
    localparam logic [3:0] SS_MASK = 4'((1 << NUM_SS) - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state;
    logic [3:0] ss_en;
    logic       cpol, cpha, lsb, done;
    logic [7:0] div, cnt, shreg, rx;
    logic [3:0] edge_idx;
    logic       wr, busy, tick, lead;
    logic [7:0] sh_in;
    logic       next_bit;

    assign wr       = bus.i_cs & bus.i_we;
    assign busy     = (state == RUN);
    assign tick     = busy && (cnt == div);
    assign lead     = ~edge_idx[0];
    // One register serves both directions: the outgoing bit leaves one end, i_miso enters the other.
    assign sh_in    = lsb ? {i_miso, shreg[7:1]} : {shreg[6:0], i_miso};
    assign next_bit = lsb ? shreg[0] : shreg[7];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            ss_en    <= 4'd0;
            cpol     <= 1'b0;
            cpha     <= 1'b0;
            lsb      <= 1'b0;
            div      <= DIV_RESET;
            cnt      <= 8'd0;
            shreg    <= 8'd0;
            rx       <= 8'd0;
            edge_idx <= 4'd0;
            done     <= 1'b0;
            o_sck    <= 1'b0;
            o_mosi   <= 1'b0;
            o_ss_n   <= '1;
        end else begin
            if (wr && bus.i_addr == 2'd0) begin
                ss_en  <= bus.i_dat[3:0] & SS_MASK;
                o_ss_n <= ~bus.i_dat[NUM_SS-1:0];
                if (!busy) begin
                    cpol  <= bus.i_dat[4];
                    o_sck <= bus.i_dat[4];
                    cpha  <= bus.i_dat[5];
`ifdef SPI_LSB_FIRST_EN
                    lsb   <= bus.i_dat[6];
`else
                    lsb   <= 1'b0;
`endif
                end
            end
            if (wr && bus.i_addr == 2'd1 && !busy)
                div <= bus.i_dat;
            // Placed before the FSM so a completing transfer's done-set overrides a same-cycle clear.
            if (wr && bus.i_addr == 2'd2 && bus.i_dat[6])
                done <= 1'b0;

            case (state)
                IDLE: begin
                    if (wr && bus.i_addr == 2'd3) begin
                        state    <= RUN;
                        done     <= 1'b0;
                        cnt      <= 8'd0;
                        edge_idx <= 4'd0;
                        shreg    <= bus.i_dat;
                        if (!cpha)
                            o_mosi <= lsb ? bus.i_dat[0] : bus.i_dat[7];
                    end
                end
                RUN: begin
                    if (tick) begin
                        cnt      <= 8'd0;
                        edge_idx <= edge_idx + 4'd1;
                        o_sck    <= ~o_sck;
                        // Sample on leading edges in CPHA=0, trailing edges in CPHA=1; shift out on the other.
                        if (lead ^ cpha)
                            shreg <= sh_in;
                        if ((lead == cpha) && (edge_idx != 4'd15))
                            o_mosi <= next_bit;
                        if (edge_idx == 4'd15) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            rx    <= cpha ? sh_in : shreg;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.o_dat = 8'h00;
        case (bus.i_addr)
            2'd0: bus.o_dat = {1'b0, lsb, cpha, cpol, ss_en};
            2'd1: bus.o_dat = div;
            2'd2: bus.o_dat = {busy, done, 6'b000000};
            2'd3: bus.o_dat = rx;
        endcase
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized SPI transfers against a behavioural SPI slave and register-level expectations.
// Honours SPI_LSB_FIRST_EN the same way the design does.
module tb_spi_master;
    localparam int         NUM_SS    = 2;
    localparam logic [7:0] DIV_RESET = 8'd3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              miso, mosi, sck;
    logic [NUM_SS-1:0] ss_n;
    logic              slv_miso = 1'b0;
    logic              loop_en  = 1'b0;

    spi_master_if bus_if ();

    spi_master #(.NUM_SS(NUM_SS), .DIV_RESET(DIV_RESET)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_if),
        .i_miso  (miso),
        .o_mosi  (mosi),
        .o_sck   (sck),
        .o_ss_n  (ss_n)
    );

    assign miso = loop_en ? mosi : slv_miso;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Current configuration as the bench believes the design holds it.
    logic              cur_cpol, cur_cpha, cur_lsb;
    int                cur_div;
    logic [NUM_SS-1:0] cur_ss;

    // Bus writes injected at given busy-cycle offsets of a transfer.
    int         n_inj = 0;
    int         inj_cyc  [4];
    logic [1:0] inj_addr [4];
    logic [7:0] inj_dat  [4];

    logic [7:0] rd, r_ctrl, r_tx, r_sb;
    int         r_div;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_if.i_cs = 1'b1; bus_if.i_we = 1'b1; bus_if.i_addr = a; bus_if.i_dat = d;
        @(negedge clk);
        bus_if.i_cs = 1'b0; bus_if.i_we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus_if.i_addr = a;
        #1;
        d = bus_if.o_dat;
    endtask

    task automatic set_mode(input logic [7:0] ctrl, input logic [7:0] div);
        bus_write(2'd0, ctrl);
        bus_write(2'd1, div);
        cur_cpol = ctrl[4];
        cur_cpha = ctrl[5];
`ifdef SPI_LSB_FIRST_EN
        cur_lsb  = ctrl[6];
`else
        cur_lsb  = 1'b0;
`endif
        cur_div  = int'(div);
        cur_ss   = ~ctrl[NUM_SS-1:0];
    endtask

    function automatic int bidx(input int k);
        return cur_lsb ? k : 7 - k;
    endfunction

    // One full transfer observed cycle by cycle at the falling clock edge, with a behavioural SPI slave.
    task automatic xfer(input string tag, input logic [7:0] tx, input logic [7:0] sb,
                        input logic loop, input logic exp_done);
        int   limit, nbusy, nedge, viol, ssbad, si, ci;
        logic prev_sck, prev_mosi, leading, finished, done_bit, first_mosi;
        logic [7:0] cap, rxd;
        limit = 16 * (cur_div + 1) + 8;
        nbusy = 0; nedge = 0; viol = 0; ssbad = 0; si = 0; ci = 0;
        finished = 1'b0; done_bit = 1'b0; first_mosi = 1'b0; cap = 8'h00;
        loop_en  = loop;
        slv_miso = sb[bidx(0)];
        @(negedge clk);
        prev_sck = sck; prev_mosi = mosi;
        bus_if.i_cs = 1'b1; bus_if.i_we = 1'b1; bus_if.i_addr = 2'd3; bus_if.i_dat = tx;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            bus_if.i_cs = 1'b0; bus_if.i_we = 1'b0; bus_if.i_addr = 2'd2; bus_if.i_dat = 8'h00;
            for (int j = 0; j < n_inj; j++) begin
                if (inj_cyc[j] == i) begin
                    bus_if.i_cs = 1'b1; bus_if.i_we = 1'b1;
                    bus_if.i_addr = inj_addr[j]; bus_if.i_dat = inj_dat[j];
                end
            end
            #1;
            if (i == 0) first_mosi = mosi;
            if (sck !== prev_sck) begin
                nedge++;
                leading = (sck !== cur_cpol);
                if (leading != cur_cpha) begin
                    if (ci < 8) cap[bidx(ci)] = mosi;
                    ci++;
                    if (mosi !== prev_mosi) viol++;
                end else if (cur_cpha) begin
                    if (si < 8) slv_miso = sb[bidx(si)];
                    si++;
                end else begin
                    si++;
                    if (si < 8) slv_miso = sb[bidx(si)];
                end
            end else if (i != 0 && mosi !== prev_mosi) begin
                viol++;
            end
            if (ss_n !== cur_ss) ssbad++;
            if (bus_if.i_addr == 2'd2 && bus_if.o_dat[7] == 1'b0) begin
                finished = 1'b1;
                done_bit = bus_if.o_dat[6];
                break;
            end
            nbusy++;
            prev_sck = sck; prev_mosi = mosi;
        end
        bus_if.i_cs = 1'b0; bus_if.i_we = 1'b0;
        check({tag, "_finish"}, 32'(finished), 32'd1);
        check({tag, "_busy_cycles"}, nbusy, 16 * (cur_div + 1));
        check({tag, "_sck_edges"}, nedge, 16);
        check({tag, "_sck_idle"}, 32'(sck), 32'(cur_cpol));
        check({tag, "_mosi_timing"}, viol, 0);
        check({tag, "_ss_hold"}, ssbad, 0);
        check({tag, "_slave_rx"}, 32'(cap), 32'(tx));
        check({tag, "_done"}, 32'(done_bit), 32'(exp_done));
        if (!cur_cpha) check({tag, "_first_mosi"}, 32'(first_mosi), 32'(tx[bidx(0)]));
        bus_read(2'd3, rxd);
        check({tag, "_rx"}, 32'(rxd), 32'(loop ? tx : sb));
        loop_en = 1'b0;
        n_inj   = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus_if.i_cs = 1'b0; bus_if.i_we = 1'b0; bus_if.i_addr = 2'd0; bus_if.i_dat = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_ss", 32'(ss_n), 32'(2'b11));
        bus_read(2'd0, rd); check("rst_ctrl", 32'(rd), 32'h00);
        bus_read(2'd1, rd); check("rst_div", 32'(rd), 32'(DIV_RESET));
        bus_read(2'd2, rd); check("rst_status", 32'(rd), 32'h00);
        bus_read(2'd3, rd); check("rst_data", 32'(rd), 32'h00);

        // Select takes effect one cycle after the write edge.
        @(negedge clk);
        bus_if.i_cs = 1'b1; bus_if.i_we = 1'b1; bus_if.i_addr = 2'd0; bus_if.i_dat = 8'h01;
        #1 check("ss_before_write", 32'(ss_n), 32'(2'b11));
        @(negedge clk);
        bus_if.i_cs = 1'b0; bus_if.i_we = 1'b0;
        #1 check("ss_after_write", 32'(ss_n), 32'(2'b10));

        set_mode(8'h01, 8'd0);
        xfer("m0_loop_a5", 8'hA5, 8'h00, 1'b1, 1'b1);

        set_mode(8'h31, 8'd3);
        check("m3_sck_idle_high", 32'(sck), 32'd1);
        xfer("m3_slave_3c", 8'($urandom_range(0, 255)), 8'h3C, 1'b0, 1'b1);

        bus_read(2'd2, rd); check("done_set", 32'(rd), 32'h40);
        bus_write(2'd2, 8'h40);
        bus_read(2'd2, rd); check("done_cleared", 32'(rd), 32'h00);

        set_mode(8'h01, 8'd3);
        n_inj = 3;
        inj_cyc[0] = 2; inj_addr[0] = 2'd3; inj_dat[0] = 8'h55;
        inj_cyc[1] = 5; inj_addr[1] = 2'd1; inj_dat[1] = 8'd9;
        inj_cyc[2] = 7; inj_addr[2] = 2'd0; inj_dat[2] = 8'h31;
        xfer("busy_ignore", 8'hF0, 8'h9E, 1'b0, 1'b1);
        bus_read(2'd1, rd); check("busy_div_kept", 32'(rd), 32'd3);
        bus_read(2'd0, rd); check("busy_ctrl_kept", 32'(rd), 32'h01);

        set_mode(8'h21, 8'd1);
        n_inj = 1;
        inj_cyc[0] = 16 * (cur_div + 1) - 1; inj_addr[0] = 2'd2; inj_dat[0] = 8'h40;
        xfer("clear_vs_set", 8'h3A, 8'hC5, 1'b0, 1'b1);

        set_mode(8'h4F, 8'd0);
        bus_read(2'd0, rd);
`ifdef SPI_LSB_FIRST_EN
        check("ctrl_readback", 32'(rd), 32'h43);
        set_mode(8'h41, 8'd0);
        xfer("lsb_loop_01", 8'h01, 8'h00, 1'b1, 1'b1);
`else
        check("ctrl_readback", 32'(rd), 32'h03);
`endif

        for (int t = 0; t < 8; t++) begin
            r_ctrl = {1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(1, 3))};
            r_div  = (t == 7) ? 255 : int'($urandom_range(0, 7));
            r_tx   = 8'($urandom_range(0, 255));
            r_sb   = 8'($urandom_range(0, 255));
            set_mode(r_ctrl, 8'(r_div));
            xfer($sformatf("rand%0d", t), r_tx, r_sb, 1'($urandom_range(0, 1)), 1'b1);
        end

        // Synchronous reset landing on the fifth tick of a mode-3 transfer.
        set_mode(8'h31, 8'd2);
        @(negedge clk);
        bus_if.i_cs = 1'b1; bus_if.i_we = 1'b1; bus_if.i_addr = 2'd3; bus_if.i_dat = 8'h96;
        @(negedge clk);
        bus_if.i_cs = 1'b0; bus_if.i_we = 1'b0;
        repeat (5 * (cur_div + 1) - 1) @(negedge clk);
        bus_read(2'd2, rd); check("pre_reset_busy", 32'(rd[7]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_sck", 32'(sck), 32'd0);
        check("abort_ss", 32'(ss_n), 32'(2'b11));
        check("abort_mosi", 32'(mosi), 32'd0);
        bus_read(2'd2, rd); check("abort_status", 32'(rd), 32'h00);
        bus_read(2'd3, rd); check("abort_data", 32'(rd), 32'h00);
        bus_read(2'd1, rd); check("abort_div", 32'(rd), 32'(DIV_RESET));
        bus_read(2'd0, rd); check("abort_ctrl", 32'(rd), 32'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
